// File: rtl/led_flow_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module : led_flow_driver_pkg
// Desc   : Shared speed/pause status encodings for the control FSM and LED driver.
// Rev    : 1.0  initial release
// ============================================================================
package led_flow_driver_pkg;

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_MID   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_PAUSE = 2'd3
    } status_e;

    localparam logic [1:0] ST_RESET = ST_MID;

endpackage : led_flow_driver_pkg
`default_nettype wire

// File: rtl/led_flow_driver_step_divider.sv
`default_nettype none
// ============================================================================
// Module : step_divider
// Desc   : Programmable step counter. The terminal count is reloaded only on tick.
// Rev    : 1.0  initial release
// ============================================================================
module step_divider #(
    parameter int               CNT_W      = 26,
    parameter logic [CNT_W-1:0] RESET_LAST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,   // terminal count: divisor minus one
    output logic             tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;
    logic             w_tick;

    // Holding en low freezes both the count and the divisor in use.
    assign w_tick = en && (r_cnt == r_last);
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_last <= RESET_LAST;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_last <= div;
        end else if (en) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule : step_divider
`default_nettype wire

// File: rtl/led_flow_driver.sv
`default_nettype none
// ============================================================================
// Module : led_flow_driver
// Desc   : Turns the speed/pause status code into a timed step pulse and a
//          running one-hot LED pattern. Define BOUNCE_EN for ping-pong motion.
// Rev    : 1.0  initial release
// ============================================================================
module led_flow_driver
    import led_flow_driver_pkg::*;
#(
    parameter int LED_N    = 8,
    parameter int DIV_LOW  = 50_000_000,
    parameter int DIV_MID  = 25_000_000,
    parameter int DIV_HIGH = 12_500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       status,
    output logic [LED_N-1:0] led,
    output logic             step,
    output logic [1:0]       cur_speed,
    output logic             paused
);

    localparam int CNT_W = $clog2(DIV_LOW);

    localparam logic [CNT_W-1:0] c_last_low  = CNT_W'(DIV_LOW  - 1);
    localparam logic [CNT_W-1:0] c_last_mid  = CNT_W'(DIV_MID  - 1);
    localparam logic [CNT_W-1:0] c_last_high = CNT_W'(DIV_HIGH - 1);
    localparam logic [LED_N-1:0] c_led_reset = {{(LED_N-1){1'b0}}, 1'b1};

    logic [LED_N-1:0] r_led;
    logic             r_step;
    logic [1:0]       r_speed;
    logic             r_paused;

    logic             w_run;
    logic             w_tick;
    logic [CNT_W-1:0] w_div_sel;
    logic [LED_N-1:0] w_next_led;

    assign w_run = (status != ST_PAUSE);

    always_comb begin
        w_div_sel = c_last_mid;
        case (status)
            ST_LOW:  w_div_sel = c_last_low;
            ST_HIGH: w_div_sel = c_last_high;
            default: w_div_sel = c_last_mid;
        endcase
    end

    step_divider #(
        .CNT_W      (CNT_W),
        .RESET_LAST (c_last_mid)
    ) u_step_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_run),
        .div   (w_div_sel),
        .tick  (w_tick)
    );

`ifdef BOUNCE_EN
    logic r_dir;        // 0 = moving left (towards MSB), 1 = moving right
    logic w_next_dir;

    always_comb begin
        w_next_dir = r_dir;
        w_next_led = r_led;
        if (!$onehot(r_led)) begin
            w_next_led = c_led_reset;
            w_next_dir = 1'b0;
        end else if (!r_dir) begin
            if (r_led[LED_N-1]) begin
                w_next_dir = 1'b1;
                w_next_led = r_led >> 1;
            end else begin
                w_next_led = r_led << 1;
            end
        end else begin
            if (r_led[0]) begin
                w_next_dir = 1'b0;
                w_next_led = r_led << 1;
            end else begin
                w_next_led = r_led >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else if (w_tick) begin
            r_dir <= w_next_dir;
        end
    end
`else
    // A corrupted pattern is repaired rather than rotated forever.
    always_comb begin
        w_next_led = c_led_reset;
        if ($onehot(r_led)) begin
            w_next_led = {r_led[LED_N-2:0], r_led[LED_N-1]};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led    <= c_led_reset;
            r_step   <= 1'b0;
            r_speed  <= ST_RESET;
            r_paused <= 1'b0;
        end else begin
            r_step   <= w_tick;
            r_paused <= !w_run;
            if (w_tick) begin
                r_led   <= w_next_led;
                r_speed <= status;
            end
        end
    end

    assign led       = r_led;
    assign step      = r_step;
    assign cur_speed = r_speed;
    assign paused    = r_paused;

endmodule : led_flow_driver
`default_nettype wire

// File: tb/tb_led_flow_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_led_flow_driver
// Desc   : Directed self-checking bench for led_flow_driver (LED_N=4, 8/4/2).
// Rev    : 1.0  initial release
// ============================================================================
module tb_led_flow_driver;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   status = 2'd1;
    logic [N-1:0] led;
    logic         step;
    logic [1:0]   cur_speed;
    logic         paused;

    always #5 clk = ~clk;

    led_flow_driver #(
        .LED_N    (N),
        .DIV_LOW  (8),
        .DIV_MID  (4),
        .DIV_HIGH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .status    (status),
        .led       (led),
        .step      (step),
        .cur_speed (cur_speed),
        .paused    (paused)
    );

    int total = 0;
    int bad   = 0;

    // Model: cycles elapsed in the current period, its length, and steps taken.
    int m_elapsed, m_period, m_speed, m_k;
    int m_step, m_paused;

    function automatic int period_for(input int s);
        if (s == 0) return 8;
        if (s == 2) return 2;
        return 4;
    endfunction

    function automatic int led_for(input int k);
        int pos;
`ifdef BOUNCE_EN
        int p;
        p   = k % (2 * (N - 1));
        pos = (p < N) ? p : 2 * (N - 1) - p;
`else
        pos = k % N;
`endif
        return 1 << pos;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " led"},       int'(led),       led_for(m_k));
        chk({tag, " step"},      int'(step),      m_step);
        chk({tag, " cur_speed"}, int'(cur_speed), m_speed);
        chk({tag, " paused"},    int'(paused),    m_paused);
    endtask

    task automatic model_reset();
        m_elapsed = 0;
        m_period  = 4;
        m_speed   = 1;
        m_k       = 0;
        m_step    = 0;
        m_paused  = 0;
    endtask

    task automatic model_edge(input int st);
        m_paused = (st == 3) ? 1 : 0;
        m_step   = 0;
        if (st != 3) begin
            m_elapsed++;
            if (m_elapsed == m_period) begin
                m_elapsed = 0;
                m_step    = 1;
                m_k++;
                m_speed   = st;
                m_period  = period_for(st);
            end
        end
    endtask

    // Drive status for one rising edge, then check at the following falling edge.
    task automatic cyc(input logic [1:0] st);
        status = st;
        model_edge(int'(st));
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst");
        chk("rst led literal",   int'(led),       1);
        chk("rst step literal",  int'(step),      0);
        chk("rst speed literal", int'(cur_speed), 1);
        chk("rst pause literal", int'(paused),    0);
        @(negedge clk);
        check_all("rst_hold");
        rst_n = 1'b1;
    endtask

    logic [N-1:0] seen [8];
    logic [N-1:0] exp6 [8];
    int           ns;

    initial begin
        // Test 1: steady mid speed, wrap after four steps.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            cyc(2'd1);
            if (i == 4) begin
                chk("t1 step@4 literal", int'(step), 1);
                chk("t1 led@4 literal",  int'(led),  2);
            end
            if (i == 8) chk("t1 step@8 literal", int'(step), 1);
`ifndef BOUNCE_EN
            if (i == 16) chk("t1 wrap@16 literal", int'(led), 1);
`endif
        end

        // Test 2: mid to high requested mid-period.
        do_reset();
        cyc(2'd1);
        for (int i = 2; i <= 10; i++) begin
            cyc(2'd2);
            if (i == 4) begin
                chk("t2 step@4 literal",  int'(step),      1);
                chk("t2 speed@4 literal", int'(cur_speed), 2);
            end
            if (i == 5) chk("t2 nostep@5 literal", int'(step), 0);
            if (i == 6) chk("t2 step@6 literal",   int'(step), 1);
        end

        // Test 3: pause mid-period for ten cycles, then resume.
        do_reset();
        cyc(2'd1);
        cyc(2'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(2'd3);
            if (i == 0) chk("t3 paused literal", int'(paused), 1);
        end
        cyc(2'd1);
        chk("t3 resume1 literal", int'(step), 0);
        cyc(2'd1);
        chk("t3 resume2 step literal", int'(step), 1);
        chk("t3 resume2 led literal",  int'(led),  2);
        cyc(2'd1);

        // Test 4: pause lands exactly on the step edge.
        do_reset();
        repeat (3) cyc(2'd1);
        cyc(2'd3);
        chk("t4 nostep literal", int'(step), 0);
        chk("t4 led literal",    int'(led),  1);
        cyc(2'd3);
        cyc(2'd3);
        cyc(2'd1);
        chk("t4 resume step literal", int'(step), 1);
        chk("t4 resume led literal",  int'(led),  2);

        // Test 5: reset mid-period at low speed.
        do_reset();
        repeat (14) cyc(2'd0);
        chk("t5 led before reset literal",   int'(led),       4);
        chk("t5 speed before reset literal", int'(cur_speed), 0);
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc(2'd0);
            if (i == 3) chk("t5 nostep@3 literal", int'(step), 0);
            if (i == 4) chk("t5 step@4 literal",   int'(step), 1);
        end

        // Test 6: first eight patterns at high speed.
`ifdef BOUNCE_EN
        exp6 = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
`else
        exp6 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        do_reset();
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(2'd2);
            if (step && ns < 8) begin
                seen[ns] = led;
                ns++;
            end
        end
        chk("t6 step count", ns, 8);
        for (int i = 0; i < 8; i++) begin
            if (i < ns) chk($sformatf("t6 pattern %0d", i), int'(seen[i]), int'(exp6[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_flow_driver
`default_nettype wire

// File: doc/led_flow_driver.md
Name: led_flow_driver

Overview:
- Consumer end of the 2-bit speed/pause status bus produced by the button control FSM. Encoding: 0 low, 1 mid, 2 high, 3 pause.
- Converts status into a timed step pulse and a rotating one-hot LED pattern (the running-light display).
- Sits between the control FSM and the board LED pins.
- Owns all timing: the control FSM only selects a rate.

Parameters:
- LED_N, 8, number of LEDs and pattern width (>=2).
- DIV_LOW, 50_000_000, clk cycles per step at low speed.
- DIV_MID, 25_000_000, clk cycles per step at mid speed.
- DIV_HIGH, 12_500_000, clk cycles per step at high speed.
- Constraint: all divisors >=2 and DIV_LOW >= DIV_MID >= DIV_HIGH.
- Counter width is $clog2(DIV_LOW).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- status  in  2  speed/pause code from the control FSM, synchronous to clk
- led  out  LED_N  one-hot LED pattern
- step  out  1  one-cycle pulse, high in the cycle the pattern advances
- cur_speed  out  2  speed code (0..2) of the divisor currently in use
- paused  out  1  registered copy of (status==3)

Behaviour:
- Reset (async, rst_n low), all outputs and internal state:
  - led = 1 (bit0 set), step = 0, cur_speed = 1, paused = 0.
  - Internal counter cnt = 0, cur_div = DIV_MID.
- status is sampled every rising edge. No handshake; status may change any cycle.
- Running (status != 3):
  - cnt increments each cycle.
  - When cnt == cur_div-1, on that edge: cnt <= 0, step <= 1 for one cycle, led rotates left: {led[LED_N-2:0], led[LED_N-1]}.
  - Step period is therefore exactly cur_div cycles.
- Speed change:
  - The new divisor is applied only at a step boundary.
  - On the step edge, cur_div and cur_speed latch the status value sampled that same edge, if it is 0..2.
  - The period in progress always completes with the old divisor, so there are no short or glitched periods.
- Pause (status == 3):
  - cnt, led, cur_div and cur_speed hold. step = 0.
  - paused = 1 one cycle after status becomes 3.
- Resume from pause:
  - cnt continues from its held value using the held cur_div.
  - The resumed status takes effect at the next step boundary.
- Simultaneous events: if status goes to 3 on the same edge where cnt == cur_div-1, pause wins. No step, and cnt holds at cur_div-1. On resume, the step fires on the first running edge.
- Wrap-around: led bit LED_N-1 rotates to bit0. The pattern stays one-hot forever.
- Illegal states: no all-zero pattern is reachable. A non-one-hot led (defensive) is forced to 1 on the next step.
- Reset mid-period or mid-pause restores the reset values immediately. Counting restarts from 0 at mid speed.

Optional Feature:
- Macro BOUNCE_EN.
- Defined: ping-pong mode.
  - Internal dir register, reset 0 = moving left.
  - When led[LED_N-1] is set, the next step reverses to moving right.
  - When led[0] is set and dir = right, the next step reverses to moving left.
  - Sequence for LED_N=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, ...
  - Pause freezes dir as well.
- Undefined: rotate-left wrap only. No dir register exists.

Decomposition:
- Shared package, also imported by the control FSM:
  - Status encodings ST_LOW=2'd0, ST_MID=2'd1, ST_HIGH=2'd2, ST_PAUSE=2'd3.
  - Reset speed constant ST_RESET=ST_MID.
- One natural sub-module, step_divider:
  - Programmable counter with inputs en and div and output tick.
  - Latches div internally on tick.
- led_flow_driver owns the pattern register, cur_speed, paused and (optionally) dir.

Test Plan:
All tests use LED_N=4, DIV_LOW=8, DIV_MID=4, DIV_HIGH=2.
- Reset release, status=1 held: step pulses on edges 4, 8 and 12 after release. led goes 0001 -> 0010 -> 0100 -> 1000, then wraps to 0001 at edge 16.
- status=1 to 2 mid-period (edge 2): the first step is still at edge 4 with cur_speed->2. Subsequent steps come every 2 cycles.
- status=3 at edge 2, held 10 cycles, then status=1:
  - paused=1 from edge 3. No step; led and cnt frozen.
  - The first step comes 2 cycles after resume.
- status=3 asserted exactly on a step edge (cnt=3): no step that cycle, and led is unchanged. The step fires on the first edge after status returns to 1.
- rst_n pulsed low mid-period at speed 0 with led=0100: outputs immediately read led=0001, step=0, cur_speed=1, paused=0. The next step is 4 cycles after release.
- BOUNCE_EN defined, status=2: led over 8 steps reads 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
